// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// mult_div_unit_pkg : op encodings and FSM states shared with the decoder
// Revision 1.0
// ============================================================================
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/md_divider.sv
`default_nettype none
// ============================================================================
// md_divider : combinational signed/unsigned 32-bit quotient/remainder
// Revision 1.0
// ============================================================================
module md_divider (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] uq;
  logic [31:0] ur;

  // Divide magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000.
  always_comb begin
    neg_a    = is_signed & dividend[31];
    neg_b    = is_signed & divisor[31];
    mag_a    = neg_a ? (32'd0 - dividend) : dividend;
    mag_b    = neg_b ? (32'd0 - divisor) : divisor;
    div_zero = (divisor == 32'd0);
    uq       = 32'd0;
    ur       = 32'd0;
    if (!div_zero) begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    quotient  = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    remainder = neg_a ? (32'd0 - ur) : ur;
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : multi-cycle E-stage multiply/divide unit owning HI/LO
// Revision 1.0
// ============================================================================
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state;
  logic [CNT_W-1:0] counter;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_valid;

  logic        is_mul;
  logic        is_div;
  logic        mul_signed;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  assign is_mul     = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign is_div     = (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign mul_signed = (md_op == MD_MULT);

  // Extending to 64 bits first makes the low 64 product bits correct for
  // both signed and unsigned operands.
  assign ext_a = {{32{mul_signed & src_a[31]}}, src_a};
  assign ext_b = {{32{mul_signed & src_b[31]}}, src_b};
  assign prod  = ext_a * ext_b;

  md_divider u_divider (
    .dividend  (src_a),
    .divisor   (src_b),
    .is_signed (md_op == MD_DIV),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      counter   <= '0;
      res_hi    <= 32'd0;
      res_lo    <= 32'd0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (is_mul || is_div)) begin
            res_hi    <= is_div ? remainder : prod[63:32];
            res_lo    <= is_div ? quotient  : prod[31:0];
            res_valid <= !(is_div && div_zero);
            counter   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy      <= 1'b1;
            state     <= S_RUN;
          end else if (md_op == MD_MTHI) begin
            hi <= src_a;
          end else if (md_op == MD_MTLO) begin
            lo <= src_a;
          end
        end
        S_RUN: begin
          // Final busy cycle: counter hits zero on this edge.
          if (counter <= CNT_W'(1)) begin
            counter <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
            if (res_valid) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mult_div_unit : directed vector table plus multi-cycle corner sequences
// Revision 1.0
// ============================================================================
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int applied = 0;
  int errors  = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op),
    .start (start),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op;
    src_a = a;
    src_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    md_op = MD_NONE;
  endtask

  // Counts busy-high samples, bounded so a stuck busy cannot hang the run.
  task automatic wait_done(input int already, output int cyc);
    cyc = already;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;
    logic        late_busy;

    vecs[0] = '{"mult_neg2x3",   MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{"multu_max",     MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2] = '{"div_neg7_2",    MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{"divu_7_2",      MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
    vecs[4] = '{"div_overflow",  MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{"mult_7xneg3",   MD_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[6] = '{"div_7_neg2",    MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7] = '{"divu_max_16",   MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[8] = '{"multu_2p32",    MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[9] = '{"div_neg8_neg3", MD_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 10};

    reset = 1'b1;
    md_op = MD_NONE;
    start = 1'b0;
    src_a = 32'd0;
    src_b = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_hi_held"}, hi, cur_hi);
      wait_done(0, cyc);
      check({vecs[i].name, "_cycles"}, 32'(cyc), 32'(vecs[i].cycles));
      check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      cur_hi = vecs[i].exp_hi;
      cur_lo = vecs[i].exp_lo;
      tick();
    end

    // mthi / mtlo then divide by zero
    md_op = MD_MTHI; src_a = 32'h00001234;
    tick();
    md_op = MD_NONE;
    check("mthi_hi", hi, 32'h00001234);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    md_op = MD_MTLO; src_a = 32'h00005678;
    tick();
    md_op = MD_NONE;
    check("mtlo_lo", lo, 32'h00005678);
    check("mtlo_hi", hi, 32'h00001234);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    launch(MD_DIV, 32'h00000009, 32'h00000000);
    wait_done(0, cyc);
    check("div0_cycles", 32'(cyc), 32'd10);
    check("div0_hi", hi, 32'h00001234);
    check("div0_lo", lo, 32'h00005678);
    launch(MD_DIVU, 32'h00000009, 32'h00000000);
    wait_done(0, cyc);
    check("divu0_cycles", 32'(cyc), 32'd10);
    check("divu0_hi", hi, 32'h00001234);
    check("divu0_lo", lo, 32'h00005678);
    tick();

    // start and mthi while busy must be ignored
    launch(MD_MULT, 32'd6, 32'd7);
    cyc = 0;
    cyc++; tick();
    cyc++; tick();
    md_op = MD_DIV; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
    cyc++; tick();
    start = 1'b0; md_op = MD_MTHI; src_a = 32'h0000AAAA;
    cyc++; tick();
    md_op = MD_NONE;
    wait_done(cyc, cyc);
    check("ignore_cycles", 32'(cyc), 32'd5);
    check("ignore_hi", hi, 32'd0);
    check("ignore_lo", lo, 32'd42);
    tick();
    check("ignore_no_relaunch", {31'd0, busy}, 32'd0);

    // reset in the middle of a divide
    md_op = MD_MTHI; src_a = 32'h00001111;
    tick();
    md_op = MD_NONE;
    launch(MD_DIV, 32'd100, 32'd3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    late_busy = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (busy !== 1'b0) late_busy = 1'b1;
    end
    check("postreset_busy", {31'd0, late_busy}, 32'd0);
    check("postreset_hi", hi, 32'd0);
    check("postreset_lo", lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
`default_nettype wire
